// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent clocked SR cells with complementary outputs.
// The S=R=1 response is fixed at elaboration by INVALID_MODE.
module sr_flip_flop #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned INVALID_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] invalid
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_invalid;
  logic [WIDTH-1:0] w_q_next;

  always_comb begin
    w_q_next = r_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      unique case ({s[i], r[i]})
        2'b10:   w_q_next[i] = 1'b1;
        2'b01:   w_q_next[i] = 1'b0;
        2'b11: begin
          // Out-of-range modes fall through to hold.
          case (INVALID_MODE)
            1:       w_q_next[i] = 1'b0;
            2:       w_q_next[i] = 1'b1;
            3:       w_q_next[i] = ~r_q[i];
            default: w_q_next[i] = r_q[i];
          endcase
        end
        default: w_q_next[i] = r_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      r_invalid <= '0;
    end else begin
      r_q       <= w_q_next;
      r_invalid <= s & r;
    end
  end

  // q_bar is derived, never stored, so it can never disagree with q.
  assign q       = r_q;
  assign q_bar   = ~r_q;
  assign invalid = r_invalid;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Directed bench for sr_flip_flop: one 1-bit instance per INVALID_MODE
// (including an out-of-range value) plus a 4-bit default-mode bank.
module tb_sr_flip_flop;

  logic       clk;
  logic       rst;
  logic       s;
  logic       r;
  logic [3:0] s4;
  logic [3:0] r4;

  logic q0, qb0, inv0;
  logic q1, qb1, inv1;
  logic q2, qb2, inv2;
  logic q3, qb3, inv3;
  logic q5, qb5, inv5;
  logic [3:0] q4w, qb4w, inv4w;

  int checks   = 0;
  int failures = 0;

  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q0), .q_bar(qb0), .invalid(inv0));
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q1), .q_bar(qb1), .invalid(inv1));
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(2)) u_m2 (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q2), .q_bar(qb2), .invalid(inv2));
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(3)) u_m3 (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q3), .q_bar(qb3), .invalid(inv3));
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(5)) u_m5 (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q5), .q_bar(qb5), .invalid(inv5));
  sr_flip_flop #(.WIDTH(4), .INVALID_MODE(0)) u_w4 (
    .clk(clk), .rst(rst), .s(s4), .r(r4), .q(q4w), .q_bar(qb4w), .invalid(inv4w));

  initial clk = 1'b0;
  always #25 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected vector order is {mode5, mode3, mode2, mode1, mode0}.
  task automatic chk_bank(input string tag, input logic [4:0] eq, input logic einv);
    chk({tag, ".q"},     {q5, q3, q2, q1, q0}, eq);
    chk({tag, ".q_bar"}, {qb5, qb3, qb2, qb1, qb0}, ~eq);
    chk({tag, ".inv"},   {inv5, inv3, inv2, inv1, inv0}, {5{einv}});
  endtask

  task automatic chk_w4(input string tag, input logic [3:0] eq, input logic [3:0] einv);
    chk({tag, ".w4q"},    {1'b0, q4w}, {1'b0, eq});
    chk({tag, ".w4qb"},   {1'b0, qb4w}, {1'b0, ~eq});
    chk({tag, ".w4inv"},  {1'b0, inv4w}, {1'b0, einv});
  endtask

  task automatic step(input logic sv, input logic rv, input logic [3:0] s4v,
                      input logic [3:0] r4v);
    @(negedge clk);
    s  = sv;
    r  = rv;
    s4 = s4v;
    r4 = r4v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    s   = 1'b1;
    r   = 1'b0;
    s4  = 4'b0000;
    r4  = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk_bank("rst_imm", 5'b00000, 1'b0);
    chk_w4("rst_imm", 4'b0000, 4'b0000);

    // Reset holds against s=1 across several edges.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_bank("rst_hold", 5'b00000, 1'b0);
    end

    // First edge after release samples normally.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_bank("rel_set", 5'b11111, 1'b0);
    chk_w4("rel", 4'b0000, 4'b0000);

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    s = 1'b0;
    r = 1'b0;
    #5 rst = 1'b1;
    #1;
    chk_bank("async_rst", 5'b00000, 1'b0);
    #4 rst = 1'b0;

    step(1'b0, 1'b0, 4'b0000, 4'b0000);
    chk_bank("tt_00", 5'b00000, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
    chk_bank("tt_01", 5'b00000, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk_bank("tt_10", 5'b11111, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b0000);
    chk_bank("tt_00_hold1", 5'b11111, 1'b0);

    // S=R=1 for two edges from q=1: {m5,m3,m2,m1,m0}.
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    chk_bank("inv_1st", 5'b10101, 1'b1);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    chk_bank("inv_2nd", 5'b11101, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 4'b0000);
    chk_bank("inv_clear", 5'b11101, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
    chk_bank("clr_all", 5'b00000, 1'b0);

    // Short set pulse well away from the rising edge.
    @(negedge clk);
    r = 1'b0;
    #5 s = 1'b1;
    #5 s = 1'b0;
    @(posedge clk);
    #1;
    chk_bank("glitch", 5'b00000, 1'b0);

    // Change on the falling edge only; rising-edge value is 0,0.
    @(negedge clk);
    s = 1'b1;
    #1 s = 1'b0;
    @(posedge clk);
    #1;
    chk_bank("fall_edge", 5'b00000, 1'b0);

    // 4-bit bank.
    step(1'b0, 1'b0, 4'b0101, 4'b0011);
    chk_w4("w4_a", 4'b0100, 4'b0001);
    step(1'b0, 1'b0, 4'b1010, 4'b0101);
    chk_w4("w4_b", 4'b1010, 4'b0000);
    step(1'b0, 1'b0, 4'b1111, 4'b1111);
    chk_w4("w4_c", 4'b1010, 4'b1111);
    step(1'b0, 1'b0, 4'b0000, 4'b0000);
    chk_w4("w4_d", 4'b1010, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
